// File: rtl/alu_pkg.sv
// Shared ALU control definitions: funct codes, ALU op encodings and sequencer states.
// Also used by the CPU main decoder, so keep the encodings stable.
package alu_pkg;

  localparam int ALU_WIDTH = 24;

  localparam logic [2:0] FUNCT_AND = 3'b000;
  localparam logic [2:0] FUNCT_OR  = 3'b001;
  localparam logic [2:0] FUNCT_ADD = 3'b010;
  localparam logic [2:0] FUNCT_MUL = 3'b011;
  localparam logic [2:0] FUNCT_SUB = 3'b110;
  localparam logic [2:0] FUNCT_SLT = 3'b111;

  localparam logic [1:0] ALUOP_AND  = 2'b00;
  localparam logic [1:0] ALUOP_OR   = 2'b01;
  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MUL_STEP = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational funct -> ALU control line decode, shared with the CPU main decoder.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] funct,
  output logic [1:0] op,
  output logic       binvert,
  output logic       cin,
  output logic       is_mul,
  output logic       illegal
);

  always_comb begin
    op      = ALUOP_AND;
    binvert = 1'b0;
    cin     = 1'b0;
    is_mul  = 1'b0;
    illegal = 1'b0;
    case (funct)
      FUNCT_AND: op = ALUOP_AND;
      FUNCT_OR:  op = ALUOP_OR;
      FUNCT_ADD: op = ALUOP_ADD;
      FUNCT_SUB: begin
        op      = ALUOP_ADD;
        binvert = 1'b1;
        cin     = 1'b1;
      end
      FUNCT_SLT: begin
        op      = ALUOP_LESS;
        binvert = 1'b1;
        cin     = 1'b1;
      end
      FUNCT_MUL: begin
        op     = ALUOP_ADD;
        is_mul = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer for the shared ripple ALU: single-pass ops take one ALU cycle,
// multiply runs as a WIDTH-step shift-add loop through the same ALU.
//   state       | meaning
//   ST_IDLE     | ready for a request, ALU lines parked at 0
//   ST_EXEC     | single-pass op on the ALU, result captured at cycle end
//   ST_MUL_STEP | one shift-add step per cycle into acc
//   ST_DONE     | response presented and held until resp_ready
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_binvert,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_zero,
  output logic             resp_err
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             binv_q, cin_q;

  logic [1:0] dec_op;
  logic       dec_binv, dec_cin, dec_is_mul, dec_illegal;

  alu_ctrl_decode u_decode (
    .funct   (req_funct),
    .op      (dec_op),
    .binvert (dec_binv),
    .cin     (dec_cin),
    .is_mul  (dec_is_mul),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_illegal)     state_nxt = ST_DONE;
          else if (dec_is_mul) state_nxt = ST_MUL_STEP;
          else                 state_nxt = ST_EXEC;
        end
      end
      ST_EXEC:     state_nxt = ST_DONE;
      ST_MUL_STEP: if (cnt == LAST_STEP) state_nxt = ST_DONE;
      ST_DONE:     if (resp_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALUOP_AND;
    alu_binvert = 1'b0;
    alu_cin     = 1'b0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_EXEC: begin
        alu_a       = opa;
        alu_b       = opb;
        alu_op      = op_q;
        alu_binvert = binv_q;
        alu_cin     = cin_q;
      end
      ST_MUL_STEP: begin
        alu_a       = acc;
        alu_b       = opb[0] ? opa : '0;
        alu_op      = op_q;
        alu_binvert = binv_q;
        alu_cin     = cin_q;
      end
      ST_DONE: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // In MUL, opa/opb double as multiplicand/multiplier shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      cnt         <= '0;
      op_q        <= ALUOP_AND;
      binv_q      <= 1'b0;
      cin_q       <= 1'b0;
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            opa    <= req_a;
            opb    <= req_b;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= dec_op;
            binv_q <= dec_binv;
            cin_q  <= dec_cin;
            if (dec_illegal) begin
              resp_result <= '0;
              resp_carry  <= 1'b0;
              resp_zero   <= 1'b1;
              resp_err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          resp_result <= alu_result;
          resp_carry  <= (op_q == ALUOP_ADD) && alu_carryout;
          resp_zero   <= (alu_result == '0);
          resp_err    <= 1'b0;
        end
        ST_MUL_STEP: begin
          acc <= alu_result;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            resp_result <= alu_result;
            resp_carry  <= 1'b0;
            resp_zero   <= (alu_result == '0);
            resp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control and sequencing unit for the shared 24-bit ripple ALU (24 one-bit slices, op[1:0] = AND/OR/ADD/LESS, bInvert, CIN).
Accepts operation requests over a valid/ready handshake and decodes funct into ALU control lines (op, bInvert, CIN).
Runs single-pass ops in one ALU cycle and 24x24 multiply as a 24-step shift-add loop through the same ALU.
Sits between the CPU decode/execute stage and the ALU datapath.

Parameters:
WIDTH, 24, datapath width; must match ALU slice count.
CNT_W, 5, step-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_funct  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL; all other codes are illegal.
req_a  input  WIDTH  operand A.
req_b  input  WIDTH  operand B.
alu_a  output  WIDTH  ALU operand A.
alu_b  output  WIDTH  ALU operand B.
alu_op  output  2  ALU op select: 00 AND, 01 OR, 10 ADD, 11 LESS.
alu_binvert  output  1  ALU bInvert.
alu_cin  output  1  carry-in to slice 0.
alu_result  input  WIDTH  ALU combinational result.
alu_carryout  input  1  carry out of slice WIDTH-1.
resp_valid  output  1  response present.
resp_ready  input  1  consumer accepts the response.
resp_result  output  WIDTH  operation result.
resp_carry  output  1  ALU carry-out for ADD/SUB; 0 otherwise.
resp_zero  output  1  asserted when resp_result == 0.
resp_err  output  1  illegal funct.

Behaviour:
- State machine: IDLE, EXEC, MUL_STEP, DONE.
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0; resp_result = 0; resp_carry = 0; resp_zero = 0; resp_err = 0; alu_* = 0; counter = 0.
- Reset is synchronous and has priority over everything. Reset mid-operation abandons the operation and drops any pending response; no response is produced for it.
- req_ready = 1 only in IDLE. A request is accepted when req_valid && req_ready; req_a, req_b and funct are registered on the accepting edge.
- Control decode (registered, stable for the whole operation):
  - AND: op 00, binv 0, cin 0.
  - OR: op 01, binv 0, cin 0.
  - ADD: op 10, binv 0, cin 0.
  - SUB: op 10, binv 1, cin 1.
  - SLT: op 11, binv 1, cin 1.
  - MUL: op 10, binv 0, cin 0.
- SLT relies on the ALU routing the sign of (A-B) into slice 0 Less; the result is that raw sign with no overflow correction.
- IDLE -> EXEC for a legal non-MUL funct:
  - In EXEC, alu_a/alu_b = registered operands.
  - At the end of EXEC, alu_result and alu_carryout are captured; resp_carry is masked to 0 for AND/OR/SLT.
  - EXEC -> DONE.
- IDLE -> DONE for an illegal funct: resp_err = 1, resp_result = 0, resp_carry = 0, resp_zero = 1.
- IDLE -> MUL_STEP for MUL:
  - Initialise acc = 0, mcand = A, mplier = B, counter = 0.
  - Each MUL_STEP cycle: alu_a = acc, alu_b = mplier[0] ? mcand : 0.
  - Update: acc <= alu_result; mcand <= mcand << 1; mplier <= mplier >> 1; counter++.
  - After step WIDTH-1 (counter == WIDTH-1), go to DONE with resp_result = acc (low WIDTH bits of the product; the high half is discarded) and resp_carry = 0.
- DONE: resp_valid = 1; resp_* held stable while resp_ready = 0. On resp_valid && resp_ready, go to IDLE.
- Latency (accepting edge to resp_valid high):
  - Single ops: 2 cycles.
  - Illegal funct: 1 cycle.
  - MUL: WIDTH + 1 = 25 cycles.
- Throughput: one operation in flight. The next request can be accepted at the earliest in the cycle after the response handshake.
- alu_* outputs return to 0 in IDLE and DONE.
- resp_zero is computed from the final resp_result.

Decomposition:
- Shared package alu_pkg holds:
  - funct codes FUNCT_AND/OR/ADD/SUB/SLT/MUL;
  - ALU op codes ALUOP_AND = 2'b00, ALUOP_OR = 2'b01, ALUOP_ADD = 2'b10, ALUOP_LESS = 2'b11;
  - state encoding;
  - WIDTH default 24.
- One sub-module, alu_ctrl_decode: combinational funct -> {op, binvert, cin, is_mul, illegal}. It is reused by the CPU main decoder.

Test Plan:
- ADD 0x000005 + 0x000003 -> resp_result 0x000008, carry 0, zero 0, resp_valid 2 cycles after accept; SUB 3 - 5 -> 0xFFFFFE, carry 0; SUB 5 - 5 -> 0x000000, carry 1, zero 1.
- SLT 3, 5 -> 0x000001; SLT 5, 3 -> 0x000000; AND 0xF0F0F0 & 0x0FF0FF -> 0x00F0F0; OR same operands -> 0xFFF0FF; check that alu_op/binv/cin match the decode table each cycle.
- MUL 0x000123 * 0x000045 -> 0x004E6F after 25 cycles, req_ready low throughout; MUL 0xFFFFFF * 0x000002 -> 0xFFFFFE (truncated).
- Backpressure: hold resp_ready = 0 for 10 cycles in DONE -> resp_valid and resp_* stable, req_ready = 0, a new req_valid is not accepted; on release the handshake completes and req_ready = 1 the next cycle.
- Illegal funct 100 -> resp_err 1, result 0, zero 1, resp_valid 1 cycle after accept; the following legal ADD returns resp_err 0.
- Assert reset at MUL step 10 -> next cycle IDLE, req_ready 1, resp_valid 0, no stale response; a subsequent ADD 1 + 1 -> 0x000002.
